output_scoreboard: RTL and testbench
====================================

Name: output_scoreboard

Overview:
- Hardware counterpart of the DNN output-side check. Consumes the per-clock output stream (a_out, y_out) from the output layer across each block cycle and decides whether each training case was classified correctly.
- Keeps running statistics: cases, errors, and correct count over the most recent WINDOW cases.
- Sits beside the DNN top, driven by the same cycle_block_counter index. Gives on-chip training-accuracy monitoring without simulator-only code.

Parameters:
- CPC, 18, clocks per block cycle (n[0]*fo[0]/z[0]+2); output samples are valid at indices 2..CPC-1.
- OUT_W, 1, output neurons delivered per clock (z[L-2]/fi[L-2]).
- WINDOW, 100, depth of the recent-accuracy history.
- CNT_W, 32, width of the case and error counters.
- MAX_CASES, 100000, case count at which done asserts.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of all statistics
- cycle_index  in  $clog2(CPC)  position within the block cycle, from cycle_block_counter
- a_out  in  OUT_W  actual thresholded outputs this clock
- y_out  in  OUT_W  ideal outputs this clock
- case_valid  out  1  one-clock pulse when a case result is published
- case_correct  out  1  result of the last case; 1 means no mismatch
- total_cases  out  CNT_W  cases evaluated
- total_errors  out  CNT_W  cases with at least one mismatch
- recent_correct  out  $clog2(WINDOW+1)  correct cases among the last WINDOW
- done  out  1  sticky; set when total_cases reaches MAX_CASES

Behaviour:
- Reset (asynchronous): all outputs 0, err_acc 0, armed 0, history all 0.
- Sample clock: any posedge clk with cycle_index >= 2.
  - mismatch = |(a_out ^ y_out).
  - err_acc <= err_acc | mismatch.
  - armed <= 1 when cycle_index == 2.
- Case close: on the sample clock with cycle_index == CPC-1 while armed:
  - final_err = err_acc | mismatch (the current sample is included).
  - Next clock:
    - case_valid = 1, case_correct = ~final_err.
    - total_cases += 1, total_errors += final_err.
    - history shifts in case_correct.
    - recent_correct = recent_correct + case_correct - oldest history bit.
  - err_acc and armed clear on the close clock.
- Latency: results are published exactly 1 clock after the CPC-1 sample clock.
- Not armed at CPC-1: occurs when reset released mid-block. No publish; the partial case is discarded.
- Aborted block: cycle_index returns to 0 or 1 without a CPC-1 sample (DNN reset, index glitch). err_acc and armed clear and nothing is published.
- Counter saturation: total_cases and total_errors saturate at all-ones and never wrap. recent_correct stays within 0..WINDOW by construction.
- done:
  - Asserts in the same clock total_cases becomes MAX_CASES.
  - While done is 1, case closes are ignored: no case_valid, counters frozen.
- clr:
  - Zeroes counters, history, recent_correct, done, err_acc and armed next clock.
  - clr coinciding with a publish: clr wins and the case is dropped.
- case_correct holds its value between pulses. case_valid is 0 at all other times.

Decomposition:
- Shared package dnn_pkg:
  - function cpc_of(n0, fo0, z0) returning n0*fo0/z0+2
  - sample-start constant FIRST_OUT_IDX = 2
  - localparam widths derived with $clog2 for cycle_index and window count
- One sub-module, window_history (WINDOW-deep 1-bit shift register plus an up/down population counter):
  - Inputs: clk, reset, clr, shift_en, bit_in.
  - Output: count.

Test Plan:
- Reset released, 3 block cycles with a_out == y_out at every index 2..17 -> 3 case_valid pulses, each 1 clock after index 17; case_correct=1; total_cases=3, total_errors=0, recent_correct=3.
- Single mismatch only at index 17 of case 2 (a_out=1, y_out=0) -> case 2 case_correct=0; total_errors=1; recent_correct=2 after 3 cases.
- Reset deasserted while cycle_index=9 -> no publish for that partial block; first case_valid occurs at the end of the next full block.
- WINDOW=4 override, pattern correct,correct,wrong,correct,correct,correct -> recent_correct sequence 1,2,2,3,3,3.
- MAX_CASES=5, 7 good blocks -> done rises with total_cases=5; blocks 6–7 give no case_valid and counters stay at 5/0. clr then returns all outputs to 0.
- cycle_index forced from 10 back to 0 with a mismatch at index 5 -> no publish, err_acc cleared; next clean block gives case_correct=1.

Source files
------------

// File: rtl/dnn_pkg.sv
// Shared constants and helpers for the DNN output-side monitoring blocks.
package dnn_pkg;

  localparam int FIRST_OUT_IDX = 2;

  function automatic int cpc_of(input int n0, input int fo0, input int z0);
    return n0 * fo0 / z0 + 2;
  endfunction

  localparam int DEF_CPC    = cpc_of(16, 1, 1);
  localparam int DEF_WINDOW = 100;
  localparam int DEF_IDX_W  = $clog2(DEF_CPC);
  localparam int DEF_WCNT_W = $clog2(DEF_WINDOW + 1);

endpackage

// File: rtl/output_scoreboard_window_history.sv
// WINDOW-deep history of case results with a running population count.
module window_history
  import dnn_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clr,
  input  logic                           shift_en,
  input  logic                           bit_in,
  output logic [$clog2(WINDOW+1)-1:0]    count
);

  localparam int CW = $clog2(WINDOW + 1);

  logic [WINDOW-1:0] hist_q, hist_d;
  logic [CW-1:0]     count_q, count_d;

  // next-state: the count tracks the shift so it never needs a full popcount
  always_comb begin
    hist_d  = hist_q;
    count_d = count_q;
    if (clr) begin
      hist_d  = '0;
      count_d = '0;
    end else if (shift_en) begin
      hist_d  = {hist_q[WINDOW-2:0], bit_in};
      count_d = count_q + CW'(bit_in) - CW'(hist_q[WINDOW-1]);
    end else begin
      hist_d  = hist_q;
      count_d = count_q;
    end
  end

  // history and count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q  <= '0;
      count_q <= '0;
    end else begin
      hist_q  <= hist_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/output_scoreboard.sv
// Per-case classification check of the output-layer stream with running
// case/error counters and a recent-accuracy window.
module output_scoreboard
  import dnn_pkg::*;
#(
  parameter int CPC       = DEF_CPC,
  parameter int OUT_W     = 1,
  parameter int WINDOW    = DEF_WINDOW,
  parameter int CNT_W     = 32,
  parameter int MAX_CASES = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr,
  input  logic [$clog2(CPC)-1:0]        cycle_index,
  input  logic [OUT_W-1:0]              a_out,
  input  logic [OUT_W-1:0]              y_out,
  output logic                          case_valid,
  output logic                          case_correct,
  output logic [CNT_W-1:0]              total_cases,
  output logic [CNT_W-1:0]              total_errors,
  output logic [$clog2(WINDOW+1)-1:0]   recent_correct,
  output logic                          done
);

  localparam int IDX_W = $clog2(CPC);
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_OUT_IDX);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CPC - 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_CASES);
  localparam logic [CNT_W-1:0] CNT_ONES  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != CNT_ONES)) ? v + CNT_ONE : v;
  endfunction

  logic mismatch_s, sample_s, close_s, final_err_s, publish_s;
  logic err_acc_q, err_acc_d, armed_q, armed_d;
  logic case_valid_q, case_valid_d, case_correct_q, case_correct_d, done_q, done_d;
  logic [CNT_W-1:0] total_cases_q, total_cases_d, total_errors_q, total_errors_d;

  // sample accumulation, case close and counter updates
  always_comb begin
    mismatch_s     = |(a_out ^ y_out);
    sample_s       = (cycle_index >= FIRST_IDX);
    close_s        = sample_s && (cycle_index == LAST_IDX) && armed_q;
    final_err_s    = err_acc_q | mismatch_s;
    publish_s      = close_s && !done_q && !clr;
    err_acc_d      = err_acc_q;
    armed_d        = armed_q;
    case_valid_d   = 1'b0;
    case_correct_d = case_correct_q;
    total_cases_d  = total_cases_q;
    total_errors_d = total_errors_q;
    done_d         = done_q;
    if (clr) begin
      err_acc_d      = 1'b0;
      armed_d        = 1'b0;
      case_correct_d = 1'b0;
      total_cases_d  = '0;
      total_errors_d = '0;
      done_d         = 1'b0;
    end else if (!sample_s) begin
      // index 0/1: either the normal gap or an aborted block; drop any partial case
      err_acc_d = 1'b0;
      armed_d   = 1'b0;
    end else if (close_s) begin
      err_acc_d = 1'b0;
      armed_d   = 1'b0;
      if (publish_s) begin
        case_valid_d   = 1'b1;
        case_correct_d = ~final_err_s;
        total_cases_d  = sat_inc(total_cases_q, 1'b1);
        total_errors_d = sat_inc(total_errors_q, final_err_s);
        done_d         = (total_cases_d == MAX_CNT);
      end else begin
        case_valid_d = 1'b0;
      end
    end else begin
      err_acc_d = final_err_s;
      armed_d   = armed_q | (cycle_index == FIRST_IDX);
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_acc_q      <= 1'b0;
      armed_q        <= 1'b0;
      case_valid_q   <= 1'b0;
      case_correct_q <= 1'b0;
      total_cases_q  <= '0;
      total_errors_q <= '0;
      done_q         <= 1'b0;
    end else begin
      err_acc_q      <= err_acc_d;
      armed_q        <= armed_d;
      case_valid_q   <= case_valid_d;
      case_correct_q <= case_correct_d;
      total_cases_q  <= total_cases_d;
      total_errors_q <= total_errors_d;
      done_q         <= done_d;
    end
  end

  window_history #(.WINDOW(WINDOW)) u_hist (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .shift_en (publish_s),
    .bit_in   (~final_err_s),
    .count    (recent_correct)
  );

  assign case_valid   = case_valid_q;
  assign case_correct = case_correct_q;
  assign total_cases  = total_cases_q;
  assign total_errors = total_errors_q;
  assign done         = done_q;

endmodule

// File: tb/tb_output_scoreboard.sv
// Scoreboard bench: three scoreboard instances (default, small MAX_CASES, small WINDOW).
module tb_output_scoreboard;

  typedef struct {
    int inst;
    int cyc;
    int cor;
    int cases;
    int errs;
    int rec;
    int dn;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        q[$];

  logic        rst_s [3];
  logic        clr_s [3];
  logic [4:0]  ci_s  [3];
  logic        ao_s  [3];
  logic        yo_s  [3];
  logic        cv    [3];
  logic        cc    [3];
  logic [31:0] tc    [3];
  logic [31:0] te    [3];
  logic        dn    [3];
  logic [6:0]  rc0;
  logic [2:0]  rc1;
  logic [2:0]  rc2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  output_scoreboard u_dut0 (
    .clk(clk), .reset(rst_s[0]), .clr(clr_s[0]), .cycle_index(ci_s[0]),
    .a_out(ao_s[0]), .y_out(yo_s[0]), .case_valid(cv[0]), .case_correct(cc[0]),
    .total_cases(tc[0]), .total_errors(te[0]), .recent_correct(rc0), .done(dn[0]));

  output_scoreboard #(.WINDOW(4), .MAX_CASES(5)) u_dut1 (
    .clk(clk), .reset(rst_s[1]), .clr(clr_s[1]), .cycle_index(ci_s[1]),
    .a_out(ao_s[1]), .y_out(yo_s[1]), .case_valid(cv[1]), .case_correct(cc[1]),
    .total_cases(tc[1]), .total_errors(te[1]), .recent_correct(rc1), .done(dn[1]));

  output_scoreboard #(.WINDOW(4)) u_dut2 (
    .clk(clk), .reset(rst_s[2]), .clr(clr_s[2]), .cycle_index(ci_s[2]),
    .a_out(ao_s[2]), .y_out(yo_s[2]), .case_valid(cv[2]), .case_correct(cc[2]),
    .total_cases(tc[2]), .total_errors(te[2]), .recent_correct(rc2), .done(dn[2]));

  function automatic int rc_of(input int w);
    return (w == 0) ? int'(rc0) : (w == 1) ? int'(rc1) : int'(rc2);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input int w);
    chk("zero_valid", int'(cv[w]), 0);
    chk("zero_correct", int'(cc[w]), 0);
    chk("zero_cases", int'(tc[w]), 0);
    chk("zero_errors", int'(te[w]), 0);
    chk("zero_recent", rc_of(w), 0);
    chk("zero_done", int'(dn[w]), 0);
  endtask

  // monitor: every publish must match the oldest expected record
  task automatic mon(input int w);
    exp_t e;
    if (cv[w]) begin
      if (q.size() == 0) begin
        chk("unexpected_publish", w, -1);
      end else begin
        e = q.pop_front();
        chk("pub_inst", w, e.inst);
        chk("pub_cycle", cyc, e.cyc);
        chk("pub_correct", int'(cc[w]), e.cor);
        chk("pub_cases", int'(tc[w]), e.cases);
        chk("pub_errors", int'(te[w]), e.errs);
        chk("pub_recent", rc_of(w), e.rec);
        chk("pub_done", int'(dn[w]), e.dn);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
    mon(2);
  end

  task automatic drv(input int w, input int idx, input bit mm);
    int v;
    @(posedge clk);
    #1;
    v = $urandom_range(0, 1);
    ci_s[w] = idx[4:0];
    yo_s[w] = v[0];
    ao_s[w] = v[0] ^ mm;
  endtask

  task automatic blk(input int w, input int from, input int to, input int mm_idx,
                     input bit pub, input int cor, input int cases, input int errs,
                     input int rec, input int dnv);
    exp_t e;
    for (int i = from; i <= to; i++) begin
      drv(w, i, i == mm_idx);
      if (i == 17 && pub) begin
        e.inst = w; e.cyc = cyc + 1; e.cor = cor; e.cases = cases;
        e.errs = errs; e.rec = rec; e.dn = dnv;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b1; clr_s[k] = 1'b0; ci_s[k] = 5'd0; ao_s[k] = 1'b0; yo_s[k] = 1'b0;
    end

    // instance 0: reset state, then release mid-block at index 9
    blk(0, 0, 8, -1, 1'b0, 0, 0, 0, 0, 0);
    chk_zero(0);
    chk_zero(1);
    drv(0, 9, 1'b0);
    rst_s[0] = 1'b0;
    blk(0, 10, 17, -1, 1'b0, 0, 0, 0, 0, 0);
    blk(0, 0, 17, -1, 1'b1, 1, 1, 0, 1, 0);
    blk(0, 0, 17, -1, 1'b1, 1, 2, 0, 2, 0);
    blk(0, 0, 17, -1, 1'b1, 1, 3, 0, 3, 0);
    blk(0, 0, 17, 17, 1'b1, 0, 4, 1, 3, 0);
    blk(0, 0, 17, -1, 1'b1, 1, 5, 1, 4, 0);
    // aborted block with a mismatch at 5, then a clean block
    blk(0, 0, 10, 5, 1'b0, 0, 0, 0, 0, 0);
    blk(0, 0, 17, -1, 1'b1, 1, 6, 1, 5, 0);
    blk(0, 0, 17, 2, 1'b1, 0, 7, 2, 5, 0);
    drv(0, 0, 1'b0);
    drv(0, 1, 1'b0);
    chk("hold_correct", int'(cc[0]), 0);
    chk("hold_valid", int'(cv[0]), 0);
    // clr on the close clock wins over the publish
    blk(0, 0, 16, -1, 1'b0, 0, 0, 0, 0, 0);
    drv(0, 17, 1'b0);
    clr_s[0] = 1'b1;
    drv(0, 0, 1'b0);
    clr_s[0] = 1'b0;
    chk_zero(0);
    blk(0, 1, 17, -1, 1'b1, 1, 1, 0, 1, 0);

    // instance 1: MAX_CASES=5, seven good blocks, then clr
    drv(1, 0, 1'b0);
    rst_s[1] = 1'b0;
    blk(1, 1, 17, -1, 1'b1, 1, 1, 0, 1, 0);
    blk(1, 0, 17, -1, 1'b1, 1, 2, 0, 2, 0);
    blk(1, 0, 17, -1, 1'b1, 1, 3, 0, 3, 0);
    blk(1, 0, 17, -1, 1'b1, 1, 4, 0, 4, 0);
    blk(1, 0, 17, -1, 1'b1, 1, 5, 0, 4, 1);
    blk(1, 0, 17, -1, 1'b0, 0, 0, 0, 0, 0);
    blk(1, 0, 17, -1, 1'b0, 0, 0, 0, 0, 0);
    drv(1, 0, 1'b0);
    chk("frozen_cases", int'(tc[1]), 5);
    chk("frozen_errors", int'(te[1]), 0);
    chk("frozen_done", int'(dn[1]), 1);
    clr_s[1] = 1'b1;
    drv(1, 0, 1'b0);
    clr_s[1] = 1'b0;
    chk_zero(1);

    // instance 2: WINDOW=4, pattern c,c,w,c,c,c
    drv(2, 0, 1'b0);
    rst_s[2] = 1'b0;
    blk(2, 1, 17, -1, 1'b1, 1, 1, 0, 1, 0);
    blk(2, 0, 17, -1, 1'b1, 1, 2, 0, 2, 0);
    blk(2, 0, 17, 9, 1'b1, 0, 3, 1, 2, 0);
    blk(2, 0, 17, -1, 1'b1, 1, 4, 1, 3, 0);
    blk(2, 0, 17, -1, 1'b1, 1, 5, 1, 3, 0);
    blk(2, 0, 17, -1, 1'b1, 1, 6, 1, 3, 0);
    drv(2, 0, 1'b0);
    drv(2, 0, 1'b0);
    drv(2, 0, 1'b0);
    chk("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
